// File: rtl/alu_resp_if.sv
// Request/response bundle between an ALU initiator and the alu_resp execution unit.
interface alu_resp_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [2:0]       req_sel;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic [3:0]       rsp_nzvc;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      rsp_count;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_nzvc, rsp_tag, rsp_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_nzvc, rsp_tag, rsp_count
  );
endinterface

// File: rtl/alu_resp.sv
// Streaming 8-op ALU: result/NZVC/tag written into a 2-entry response FIFO on accept (1-cycle latency).
// req_ready depends only on registered fill level; consumer stalls hold the head stable.
module alu_resp #(
  parameter int TAG_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_resp_if.slave  bus
);

  typedef struct packed {
    logic [7:0]       result;
    logic [3:0]       nzvc;
    logic [TAG_W-1:0] tag;
  } rsp_ent_t;

  rsp_ent_t    mem_q [2];
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [15:0] rsp_count_q, rsp_count_d;
  logic        init_q;
  logic        push, pop;
  rsp_ent_t    alu_ent;

  logic [7:0]  opb;
  logic [8:0]  sum9;
  logic [7:0]  res;
  logic        ovf, cry;

  always_comb begin
    opb  = bus.req_b;
    sum9 = '0;
    res  = '0;
    ovf  = 1'b0;
    cry  = 1'b0;
    if (bus.req_sel == 3'd1 || bus.req_sel == 3'd3) begin
      opb = 8'd1;
    end
    case (bus.req_sel)
      3'd0, 3'd1: begin
        sum9 = {1'b0, bus.req_a} + {1'b0, opb};
        res  = sum9[7:0];
        cry  = sum9[8];
        ovf  = (bus.req_a[7] == opb[7]) && (res[7] != bus.req_a[7]);
      end
      3'd2, 3'd3: begin
        // Bit 8 of the 9-bit difference is the unsigned borrow.
        sum9 = {1'b0, bus.req_a} - {1'b0, opb};
        res  = sum9[7:0];
        cry  = sum9[8];
        ovf  = (bus.req_a[7] != opb[7]) && (res[7] != bus.req_a[7]);
      end
      3'd4:    res = bus.req_a & bus.req_b;
      3'd5:    res = bus.req_a | bus.req_b;
      3'd6:    res = bus.req_a ^ bus.req_b;
      default: res = ~bus.req_a;
    endcase
    alu_ent.result = res;
    alu_ent.nzvc   = {res[7], (res == 8'h00), ovf, cry};
    alu_ent.tag    = bus.req_tag;
  end

  // init_q keeps req_ready low until the first edge after reset releases.
  assign bus.req_ready = rst_n && init_q && (count_q != 2'd2);
  assign bus.rsp_valid = (count_q != 2'd0);

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    rsp_count_d = rsp_count_q + {15'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rsp_count_q <= 16'd0;
      init_q      <= 1'b0;
    end else begin
      init_q      <= 1'b1;
      count_q     <= count_d;
      rsp_count_q <= rsp_count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= alu_ent;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.rsp_result = mem_q[rd_ptr_q].result;
  assign bus.rsp_nzvc   = mem_q[rd_ptr_q].nzvc;
  assign bus.rsp_tag    = mem_q[rd_ptr_q].tag;
  assign bus.rsp_count  = rsp_count_q;

endmodule

// File: tb/tb_alu_resp.sv
// Directed bench for alu_resp: literal vectors plus a queue-based scoreboard checked every cycle.
module tb_alu_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_resp_if #(.TAG_W(4)) bus_if ();

  alu_resp #(.TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU from arithmetic on true integer values: {result, N, Z, V, C}.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic v, c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sel == 3'd1 || sel == 3'd3) begin
      ub = 1;
      sb = 1;
    end
    v = 1'b0;
    c = 1'b0;
    r = 8'h00;
    case (sel)
      3'd0, 3'd1: begin
        u = ua + ub;
        s = sa + sb;
        r = u[7:0];
        c = (u > 255);
        v = (s > 127) || (s < -128);
      end
      3'd2, 3'd3: begin
        u = ua - ub;
        s = sa - sb;
        r = u[7:0];
        c = (ua < ub);
        v = (s > 127) || (s < -128);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~a;
    endcase
    return {r, r[7], (r == 8'h00), v, c};
  endfunction

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
    logic [3:0] t;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_cnt = 16'd0;
  bit          m_init = 1'b0;
  bit          m_fresh = 1'b0;
  bit          m_known = 1'b0;

  // Scoreboard: update the model at each edge, compare shortly after.
  always @(posedge clk) begin
    bit do_push, do_pop;
    logic [11:0] x;
    if (!rst_n) begin
      q.delete();
      m_cnt   = 16'd0;
      m_init  = 1'b0;
      m_fresh = 1'b1;
      m_known = 1'b1;
    end else if (m_known) begin
      do_push = bus_if.req_valid && m_init && (q.size() < 2);
      do_pop  = (q.size() > 0) && bus_if.rsp_ready;
      x = ref_alu(bus_if.req_a, bus_if.req_b, bus_if.req_sel);
      if (do_pop) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (do_push) begin
        q.push_back('{r: x[11:4], f: x[3:0], t: bus_if.req_tag});
        m_fresh = 1'b0;
      end
      m_init = 1'b1;
    end
    #1;
    if (m_known) begin
      chk("sb_rsp_valid", 32'(bus_if.rsp_valid), 32'(q.size() != 0));
      chk("sb_req_ready", 32'(bus_if.req_ready), 32'((rst_n === 1'b1) && m_init && (q.size() < 2)));
      chk("sb_rsp_count", 32'(bus_if.rsp_count), 32'(m_cnt));
      if (q.size() != 0) begin
        chk("sb_result", 32'(bus_if.rsp_result), 32'(q[0].r));
        chk("sb_nzvc",   32'(bus_if.rsp_nzvc),   32'(q[0].f));
        chk("sb_tag",    32'(bus_if.rsp_tag),    32'(q[0].t));
      end else if (m_fresh) begin
        chk("sb_rst_result", 32'(bus_if.rsp_result), 32'h0);
        chk("sb_rst_nzvc",   32'(bus_if.rsp_nzvc),   32'h0);
        chk("sb_rst_tag",    32'(bus_if.rsp_tag),    32'h0);
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                       input logic [3:0] tag);
    bus_if.req_valid = 1'b1;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    bus_if.req_sel   = sel;
    bus_if.req_tag   = tag;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0]  va [11];
  logic [7:0]  vb [11];
  logic [2:0]  vs [11];
  logic [11:0] vx [11];

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_a     = 8'h00;
    bus_if.req_b     = 8'h00;
    bus_if.req_sel   = 3'd0;
    bus_if.req_tag   = 4'h0;
    bus_if.rsp_ready = 1'b0;

    va[0]  = 8'd100; vb[0]  = 8'h88; vs[0]  = 3'd0; vx[0]  = {8'hEC, 4'b1000};
    va[1]  = 8'd127; vb[1]  = 8'h00; vs[1]  = 3'd1; vx[1]  = {8'h80, 4'b1010};
    va[2]  = 8'hFF;  vb[2]  = 8'h00; vs[2]  = 3'd1; vx[2]  = {8'h00, 4'b0101};
    va[3]  = 8'h80;  vb[3]  = 8'h00; vs[3]  = 3'd3; vx[3]  = {8'h7F, 4'b0010};
    va[4]  = 8'd17;  vb[4]  = 8'd40; vs[4]  = 3'd2; vx[4]  = {8'hE9, 4'b1001};
    va[5]  = 8'd73;  vb[5]  = 8'hA3; vs[5]  = 3'd2; vx[5]  = {8'hA6, 4'b1011};
    va[6]  = 8'd78;  vb[6]  = 8'd121; vs[6] = 3'd4; vx[6]  = {8'h48, 4'b0000};
    va[7]  = 8'd78;  vb[7]  = 8'd121; vs[7] = 3'd5; vx[7]  = {8'h7F, 4'b0000};
    va[8]  = 8'd78;  vb[8]  = 8'd121; vs[8] = 3'd6; vx[8]  = {8'h37, 4'b0000};
    va[9]  = 8'd78;  vb[9]  = 8'd121; vs[9] = 3'd7; vx[9]  = {8'hB1, 4'b1000};
    va[10] = 8'h00;  vb[10] = 8'hFF; vs[10] = 3'd4; vx[10] = {8'h00, 4'b0100};

    // Reset state
    do_reset();
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
    chk("rst_result",    32'(bus_if.rsp_result), 32'h0);
    chk("rst_nzvc",      32'(bus_if.rsp_nzvc),   32'h0);
    chk("rst_count",     32'(bus_if.rsp_count),  32'h0);
    chk("rst_req_ready", 32'(bus_if.req_ready),  32'h1);

    // Backpressure: tags 1,2 fill the buffer, tag 3 waits
    drive(8'd1, 8'd1, 3'd0, 4'd1);
    @(negedge clk);
    drive(8'd2, 8'd2, 3'd0, 4'd2);
    @(negedge clk);
    drive(8'd3, 8'd3, 3'd0, 4'd3);
    @(negedge clk);
    chk("bp_full_ready", 32'(bus_if.req_ready), 32'h0);
    chk("bp_head_tag1",  32'(bus_if.rsp_tag),   32'h1);
    @(negedge clk);
    chk("bp_hold_ready", 32'(bus_if.req_ready), 32'h0);
    chk("bp_hold_tag1",  32'(bus_if.rsp_tag),   32'h1);
    chk("bp_hold_res",   32'(bus_if.rsp_result), 32'h2);
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_tag2",  32'(bus_if.rsp_tag),   32'h2);
    chk("bp_reopen",     32'(bus_if.req_ready), 32'h1);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk("bp_head_tag3",  32'(bus_if.rsp_tag),   32'h3);
    @(negedge clk);
    chk("bp_drained",    32'(bus_if.rsp_valid), 32'h0);
    chk("bp_count3",     32'(bus_if.rsp_count), 32'h3);

    // Directed ALU vectors, one per cycle, consumer always ready
    for (int i = 0; i < 11; i++) begin
      chk("model_pin", 32'(ref_alu(va[i], vb[i], vs[i])), 32'(vx[i]));
      if (i > 0) begin
        chk("vec_result", 32'(bus_if.rsp_result), 32'(vx[i-1][11:4]));
        chk("vec_nzvc",   32'(bus_if.rsp_nzvc),   32'(vx[i-1][3:0]));
        chk("vec_tag",    32'(bus_if.rsp_tag),    32'(i - 1));
      end
      drive(va[i], vb[i], vs[i], 4'(i));
      @(negedge clk);
    end
    bus_if.req_valid = 1'b0;
    chk("vec_result", 32'(bus_if.rsp_result), 32'(vx[10][11:4]));
    chk("vec_nzvc",   32'(bus_if.rsp_nzvc),   32'(vx[10][3:0]));
    @(negedge clk);

    // Simultaneous push/pop with one entry buffered
    bus_if.rsp_ready = 1'b0;
    drive(8'd5, 8'd9, 3'd2, 4'd0);
    @(negedge clk);
    bus_if.rsp_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(8'(i * 13), 8'(i * 7), 3'(i), 4'(i));
      @(negedge clk);
      chk("pp_valid", 32'(bus_if.rsp_valid), 32'h1);
      chk("pp_ready", 32'(bus_if.req_ready), 32'h1);
      chk("pp_tag",   32'(bus_if.rsp_tag),   32'(i));
    end
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk("pp_drained", 32'(bus_if.rsp_valid), 32'h0);

    // Reset with a full buffer and a request pending
    bus_if.rsp_ready = 1'b0;
    drive(8'd5, 8'd6, 3'd0, 4'd5);
    @(negedge clk);
    drive(8'd7, 8'd8, 3'd5, 4'd6);
    @(negedge clk);
    drive(8'd9, 8'd1, 3'd6, 4'd7);
    chk("mr_full", 32'(bus_if.rsp_valid), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_valid", 32'(bus_if.rsp_valid), 32'h0);
    chk("mr_count", 32'(bus_if.rsp_count), 32'h0);
    chk("mr_ready", 32'(bus_if.req_ready), 32'h0);
    rst_n = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_empty", 32'(bus_if.rsp_valid), 32'h0);
    end

    // Sustained streaming up to the rsp_count wrap point
    for (int i = 0; i < 65535; i++) begin
      drive(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
      @(negedge clk);
    end
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk("wrap_ffff", 32'(bus_if.rsp_count), 32'hFFFF);
    drive(8'd1, 8'd2, 3'd0, 4'd9);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk("wrap_zero", 32'(bus_if.rsp_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
